// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the EX-stage multiply/divide unit.
//   - funct3 encodings of the RV32M operations (OP_MUL..OP_REMU)
//   - state encoding of the iterative mul/div FSM
//   - number of iteration steps per operation
package cpu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_ctrl.sv
// muldiv_sign_ctrl: combinational sign handling around the unsigned
// shift-add / shift-subtract core.
//   Accept side:
//     op, rs1_val, rs2_val  -> a_mag, b_mag      operand magnitudes
//                           -> res_neg, rem_neg  result signs
//                           -> special, special_result  cases resolved without iterating
//   Finish side:
//     fin_op, fin_acc, fin_res_neg, fin_rem_neg -> final_result
//     fin_acc is the 64-bit product, or {remainder, quotient} for divides.
module muldiv_sign_ctrl
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        res_neg,
  output logic        rem_neg,
  output logic        special,
  output logic [31:0] special_result,
  input  logic [2:0]  fin_op,
  input  logic [63:0] fin_acc,
  input  logic        fin_res_neg,
  input  logic        fin_rem_neg,
  output logic [31:0] final_result
);

  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic        div_by_zero;
  logic        div_overflow;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && rs1_val[31];
    b_neg    = b_signed && rs2_val[31];
    // 0x80000000 negates to itself, which is still the correct unsigned magnitude.
    a_mag    = a_neg ? (~rs1_val + 32'd1) : rs1_val;
    b_mag    = b_neg ? (~rs2_val + 32'd1) : rs2_val;
    res_neg  = a_neg ^ b_neg;
    rem_neg  = a_neg;

    div_by_zero  = op[2] && (rs2_val == 32'd0);
    div_overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                   (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
    special      = div_by_zero || div_overflow;

    // op[1] selects the remainder flavours (REM/REMU) among the divides.
    special_result = 32'd0;
    if (div_by_zero)
      special_result = op[1] ? rs1_val : 32'hFFFF_FFFF;
    else if (div_overflow)
      special_result = op[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    prod = fin_res_neg ? (~fin_acc + 64'd1) : fin_acc;
    quot = fin_acc[31:0];
    rem  = fin_acc[63:32];
    if (!fin_op[2])
      final_result = (fin_op == OP_MUL) ? prod[31:0] : prod[63:32];
    else if (fin_op[1])
      final_result = fin_rem_neg ? (~rem + 32'd1) : rem;
    else
      final_result = fin_res_neg ? (~quot + 32'd1) : quot;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
//   clk, clr      clock / asynchronous active-high reset
//   start         EX holds an M instruction with valid operands
//   op            funct3 (MUL..REMU)
//   rs1_val/rs2_val  forwarded operands
//   flush         aborts an operation in progress (priority over start)
//   stall         holds PC/front-end from the accept cycle through the last step
//   done          one-cycle pulse with result valid
//   result        registered result, held until the next completion
// Multiplies use a 64-bit accumulator {high partial sum, shifting multiplier};
// divides reuse the same register as {partial remainder, dividend->quotient}.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] LAST_STEP = 6'(MULDIV_STEPS - 1);

  muldiv_state_t state_reg;
  logic [5:0]    count_reg;
  logic [2:0]    op_reg;
  logic [31:0]   opnd_reg;      // multiplicand for multiplies, divisor for divides
  logic [63:0]   acc_reg;
  logic          res_neg_reg;
  logic          rem_neg_reg;
  logic [31:0]   result_reg;
  logic          done_reg;

  logic          accept;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic          res_neg;
  logic          rem_neg;
  logic          special;
  logic [31:0]   special_result;
  logic [31:0]   final_result;
  logic [63:0]   acc_step;
  logic [32:0]   mul_sum;
  logic [32:0]   div_diff;

  muldiv_sign_ctrl u_sign_ctrl (
    .op             (op),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .a_mag          (a_mag),
    .b_mag          (b_mag),
    .res_neg        (res_neg),
    .rem_neg        (rem_neg),
    .special        (special),
    .special_result (special_result),
    .fin_op         (op_reg),
    .fin_acc        (acc_step),
    .fin_res_neg    (res_neg_reg),
    .fin_rem_neg    (rem_neg_reg),
    .final_result   (final_result)
  );

  assign accept = (state_reg == ST_IDLE) && start && !flush;
  assign stall  = accept || (state_reg == ST_CALC);
  assign done   = done_reg;
  assign result = result_reg;

  // One iteration of either algorithm.
  always_comb begin
    // Multiply: add the multiplicand into the high half if the multiplier LSB
    // is set, then shift the whole accumulator right one bit.
    mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    // Divide: shift {rem, dividend} left one bit and try to subtract the divisor
    // from the 33-bit partial remainder; restore on a borrow.
    div_diff = acc_reg[63:31] - {1'b0, opnd_reg};
    if (!op_reg[2])
      acc_step = {mul_sum, acc_reg[31:1]};
    else if (div_diff[32])
      acc_step = {acc_reg[62:0], 1'b0};
    else
      acc_step = {div_diff[31:0], acc_reg[30:0], 1'b1};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= ST_IDLE;
      count_reg   <= 6'd0;
      op_reg      <= OP_MUL;
      opnd_reg    <= 32'd0;
      acc_reg     <= 64'd0;
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      result_reg  <= 32'd0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg      <= op;
            res_neg_reg <= res_neg;
            rem_neg_reg <= rem_neg;
            count_reg   <= 6'd0;
            if (op[2]) begin
              opnd_reg <= b_mag;
              acc_reg  <= {32'd0, a_mag};
            end else begin
              opnd_reg <= a_mag;
              acc_reg  <= {32'd0, b_mag};
            end
            if (special) begin
              result_reg <= special_result;
              done_reg   <= 1'b1;
              state_reg  <= ST_FIN;
            end else begin
              state_reg  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            count_reg <= 6'd0;
          end else begin
            acc_reg <= acc_step;
            if (count_reg == LAST_STEP) begin
              result_reg <= final_result;
              done_reg   <= 1'b1;
              count_reg  <= 6'd0;
              state_reg  <= ST_FIN;
            end else begin
              count_reg <= count_reg + 6'd1;
            end
          end
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed RV32M vectors with hand-computed
// results, plus a per-cycle comparison of stall/done/result against a
// transaction-level model built from plain 64-bit arithmetic.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_no   = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Architectural RV32M result from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Transaction model: an accepted op keeps EX busy for 32 cycles (unless it
  // is a special case), then completes with a one-cycle done.
  int          m_busy    = 0;
  bit          m_fin     = 1'b0;
  logic [31:0] m_result  = 32'd0;
  logic [31:0] m_pending = 32'd0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy   <= 0;
      m_fin    <= 1'b0;
      m_result <= 32'd0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (m_busy > 0) begin
      if (flush) begin
        m_busy <= 0;
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_fin    <= 1'b1;
          m_result <= m_pending;
        end
      end
    end else if (start && !flush) begin
      if (ref_special(op, rs1_val, rs2_val)) begin
        m_fin    <= 1'b1;
        m_result <= ref_result(op, rs1_val, rs2_val);
      end else begin
        m_busy    <= 32;
        m_pending <= ref_result(op, rs1_val, rs2_val);
      end
    end
  end

  bit checks_en = 1'b0;

  always @(negedge clk) begin
    cyc_no++;
    if (checks_en) begin
      check("cyc_stall", {31'd0, stall},
            {31'd0, (m_busy > 0) || (!clr && !m_fin && m_busy == 0 && start && !flush)});
      check("cyc_done", {31'd0, done}, {31'd0, m_fin});
      check("cyc_result", result, m_result);
    end
  end

  // Issue one op at posedge+2 and wait (bounded) for done.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    logic [31:0] res = 32'd0;
    check({"model_", name}, ref_result(f, a, b), exp);
    start = 1'b1; op = f; rs1_val = a; rs2_val = b;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        res = result;
      end
      @(posedge clk); #2;
      start = 1'b0;
      if (!got) lat++;
    end
    check({"done_seen_", name}, {31'd0, got}, 32'd1);
    check({"lat_", name}, lat, exp_lat);
    check({"res_", name}, res, exp);
    $display("op %s f=%0d a=%h b=%h -> result %h latency %0d", name, f, a, b, res, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    checks_en = 1'b1;
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #2;

    run_op("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULH",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("DIVU",   3'd5, 32'd100,        32'd7,         32'd14,        33);
    run_op("REMU",   3'd7, 32'd100,        32'd7,         32'd2,         33);
    run_op("DIVU_0", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("REM_0",  3'd6, 32'd5,          32'd0,         32'd5,         1);
    run_op("DIV_OV", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM_OV", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Flush on CALC step 10.
    start = 1'b1; op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3;
    @(posedge clk); #2 start = 1'b0;
    repeat (10) begin @(posedge clk); #2; end
    flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    check("flush_stall_low", {31'd0, stall}, 32'd0);
    check("flush_no_done", {31'd0, done}, 32'd0);
    $display("flush at step 10: stall=%0d done=%0d", stall, done);
    repeat (30) @(posedge clk);
    #2;
    run_op("DIVU_after_flush", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous clear in the middle of a calculation.
    start = 1'b1; op = 3'd3; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    clr = 1'b1;
    #1;
    check("clr_stall", {31'd0, stall}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_result", result, 32'd0);
    $display("clr mid-CALC: stall=%0d done=%0d result=%h", stall, done, result);
    @(posedge clk); #2 clr = 1'b0;

    // start together with flush must not be accepted.
    start = 1'b1; flush = 1'b1; op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3;
    #1;
    check("start_flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_idle_stall", {31'd0, stall}, 32'd0);
    check("start_flush_no_done", {31'd0, done}, 32'd0);
    $display("start+flush: stall=%0d done=%0d", stall, done);
    @(posedge clk); #2;

    run_op("MUL_after_clr", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    repeat (3) @(posedge clk);
    checks_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
